// File: rtl/ntt_pkg.sv
// Shared definitions for the R16 NTT result path: geometry constants and the
// scheduler state encoding.
package ntt_pkg;

  localparam int NTT_LANES  = 16;
  localparam int NTT_BEATS  = 1024;
  localparam int NTT_BEAT_W = 10;
  localparam int NTT_ROT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ntt_state_e;

endpackage

// File: rtl/ntt_result_sched_if.sv
// Result-path bus between the NTT datapath, the scheduler and the consumer.
//
// Handshake (both directions): a beat transfers on a rising clk edge where
// valid & ready are both high. A source that raises valid keeps it and its
// data/flags unchanged until the transfer; ready may move freely and never
// depends combinationally on valid.
interface ntt_result_sched_if
  import ntt_pkg::*;
#(
  parameter int P_WIDTH = 64
);

  localparam int DW = NTT_LANES * P_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof
  );

endinterface

// File: rtl/ntt_lane_rotate.sv
// Combinational barrel rotate of the 16 result lanes. The rotation amount is
// derived from the beat index so that consecutive beats land on different
// banks; output lane i takes input lane (i + rot) mod 16.
module ntt_lane_rotate
  import ntt_pkg::*;
#(
  parameter int P_WIDTH = 64
) (
  input  logic [NTT_BEAT_W-1:0]        beat_i,
  input  logic [NTT_LANES*P_WIDTH-1:0] data_i,
  output logic [NTT_LANES*P_WIDTH-1:0] data_o
);

  logic [NTT_ROT_W-1:0] rot;
  logic [NTT_ROT_W-1:0] src [NTT_LANES];

  // Sum of the three index nibbles; the 4-bit result wraps mod 16 naturally.
  assign rot = beat_i[3:0] + beat_i[7:4] + {2'b00, beat_i[9:8]};

  for (genvar i = 0; i < NTT_LANES; i++) begin : g_lane
    // Source lane select, mod 16 via 4-bit wrap.
    assign src[i] = rot + 4'(i);
    assign data_o[i*P_WIDTH +: P_WIDTH] = data_i[src[i]*P_WIDTH +: P_WIDTH];
  end

endmodule

// File: rtl/ntt_result_sched.sv
// Output scheduler for the 16-lane NTT result path: frames each 1024-beat
// transform, rotates lanes per beat and buffers results in a 2-entry skid FIFO
// whose head drives the output bus directly from registers.
module ntt_result_sched
  import ntt_pkg::*;
#(
  parameter int P_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ntt_result_sched_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output ntt_state_e           dbg_state
);

  localparam int DW = NTT_LANES * P_WIDTH;
  localparam logic [NTT_BEAT_W-1:0] LAST_BEAT = NTT_BEAT_W'(NTT_BEATS - 1);

  ntt_state_e            state_q;
  logic [NTT_BEAT_W-1:0] beat_q;

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          sof0_q, sof0_d, eof0_q, eof0_d;
  logic          sof1_q, sof1_d, eof1_q, eof1_d;

  logic          push, pop;
  logic          push_sof, push_eof;
  logic [DW-1:0] rot_data;

  ntt_lane_rotate #(.P_WIDTH(P_WIDTH)) u_rotate (
    .beat_i (beat_q),
    .data_i (bus.in_data),
    .data_o (rot_data)
  );

  // Ready depends only on state and occupancy, never on valid or out_ready.
  assign bus.in_ready  = (state_q == RUN) && (count_q != 2'd2);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (count_q != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;

  assign push_sof = (beat_q == '0);
  assign push_eof = (beat_q == LAST_BEAT);

  assign bus.out_data = data0_q;
  assign bus.out_sof  = sof0_q;
  assign bus.out_eof  = eof0_q;

  // done marks the cycle in which the eof beat leaves the scheduler.
  assign done      = (state_q == DRAIN) && pop && eof0_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Transform framing FSM and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            beat_q  <= '0;
          end
        end
        RUN: begin
          if (push) begin
            beat_q <= beat_q + 1'b1;
            if (push_eof) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Skid FIFO next state: slot 0 is always the head; slot 1 only fills when
  // the head is occupied and not leaving.
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    sof0_d  = sof0_q;
    eof0_d  = eof0_q;
    data1_d = data1_q;
    sof1_d  = sof1_q;
    eof1_d  = eof1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = rot_data;
          sof0_d  = push_sof;
          eof0_d  = push_eof;
        end else begin
          data1_d = rot_data;
          sof1_d  = push_sof;
          eof1_d  = push_eof;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        sof0_d  = sof1_q;
        eof0_d  = eof1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1: the new beat replaces the leaving head.
        data0_d = rot_data;
        sof0_d  = push_sof;
        eof0_d  = push_eof;
      end
      default: ;
    endcase
  end

  // Skid FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      data0_q <= '0;
      sof0_q  <= 1'b0;
      eof0_q  <= 1'b0;
      data1_q <= '0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      data0_q <= data0_d;
      sof0_q  <= sof0_d;
      eof0_q  <= eof0_d;
      data1_q <= data1_d;
      sof1_q  <= sof1_d;
      eof1_q  <= eof1_d;
    end
  end

endmodule
